// File: rtl/alt_vipcti131_common_field_counter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alt_vipcti131_common_field_counter_pkg
// Shared widths, tick-mode encoding and total conversion for the field counter.
// Revision: 1.0
// ---------------------------------------------------------------------------
package alt_vipcti131_common_field_counter_pkg;

  localparam int DEFAULT_H_WIDTH                 = 14;
  localparam int DEFAULT_V_WIDTH                 = 13;
  localparam int DEFAULT_NUMBER_OF_COLOUR_PLANES = 3;
  localparam int TOTAL_CALC_WIDTH                = 32;

  typedef enum logic {
    TICK_PARALLEL   = 1'b0,
    TICK_SEQUENTIAL = 1'b1
  } tick_mode_t;

  function automatic int sample_tick_width(input int planes);
    int w;
    w = $clog2(planes);
    return (w < 1) ? 1 : w;
  endfunction

  // Converts a programmed total into the index of the last position; a zero
  // total behaves like a total of one so the comparison never underflows.
  function automatic logic [TOTAL_CALC_WIDTH-1:0] total_to_last(
    input logic [TOTAL_CALC_WIDTH-1:0] total,
    input logic                        totals_minus_one
  );
    if (totals_minus_one) begin
      return total;
    end else if (total == '0) begin
      return '0;
    end else begin
      return total - TOTAL_CALC_WIDTH'(1);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/alt_vipcti131_common_sample_tick_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alt_vipcti131_common_sample_tick_counter
// Colour-plane tick counter producing start_of_sample and count_sample.
// Revision: 1.0
// ---------------------------------------------------------------------------
module alt_vipcti131_common_sample_tick_counter
  import alt_vipcti131_common_field_counter_pkg::*;
#(
  parameter int NUMBER_OF_COLOUR_PLANES       = DEFAULT_NUMBER_OF_COLOUR_PLANES,
  parameter int COLOUR_PLANES_ARE_IN_PARALLEL = 1,
  parameter int TICK_WIDTH                    = sample_tick_width(NUMBER_OF_COLOUR_PLANES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclr,
  input  logic                  enable,
  input  logic                  hd_sdn,
  output logic [TICK_WIDTH-1:0] ticks,
  output logic                  start_of_sample,
  output logic                  count_sample
);

  localparam logic [TICK_WIDTH-1:0] LAST_TICK = TICK_WIDTH'(NUMBER_OF_COLOUR_PLANES - 1);

  tick_mode_t mode;
  logic       at_last;

  generate
    if (COLOUR_PLANES_ARE_IN_PARALLEL == 0) begin : g_sequential
      // HD streams carry a whole sample per cycle even on a sequential bus.
      assign mode = hd_sdn ? TICK_PARALLEL : TICK_SEQUENTIAL;
    end else begin : g_parallel
      logic unused_hd_sdn;
      assign unused_hd_sdn = hd_sdn;
      assign mode          = TICK_PARALLEL;
    end
  endgenerate

  assign at_last = (ticks == LAST_TICK);

  always_ff @(posedge clk) begin
    if (rst || sclr) begin
      ticks <= '0;
    end else if (mode == TICK_PARALLEL) begin
      ticks <= '0;
    end else if (enable) begin
      ticks <= at_last ? '0 : ticks + TICK_WIDTH'(1);
    end
  end

  assign count_sample    = enable & ((mode == TICK_PARALLEL) | at_last);
  assign start_of_sample = enable & (ticks == '0);

endmodule
`default_nettype wire

// File: rtl/alt_vipcti131_common_field_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alt_vipcti131_common_field_counter
// Raster position, line/frame event and interlaced field tracker.
// Revision: 1.0
// ---------------------------------------------------------------------------
module alt_vipcti131_common_field_counter
  import alt_vipcti131_common_field_counter_pkg::*;
#(
  parameter int H_WIDTH                       = DEFAULT_H_WIDTH,
  parameter int V_WIDTH                       = DEFAULT_V_WIDTH,
  parameter int NUMBER_OF_COLOUR_PLANES       = DEFAULT_NUMBER_OF_COLOUR_PLANES,
  parameter int COLOUR_PLANES_ARE_IN_PARALLEL = 1,
  parameter int LOG2_NUMBER_OF_COLOUR_PLANES  = sample_tick_width(NUMBER_OF_COLOUR_PLANES),
  parameter int TOTALS_MINUS_ONE              = 0,
  parameter int INTERLACED_SUPPORT            = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    sclr,
  input  logic                                    enable,
  input  logic                                    hd_sdn,
  input  logic                                    interlaced,
  input  logic [H_WIDTH-1:0]                      h_total,
  input  logic [V_WIDTH-1:0]                      v_total,
  input  logic [V_WIDTH-1:0]                      f_rise_line,
  input  logic [V_WIDTH-1:0]                      f_fall_line,
  input  logic [H_WIDTH-1:0]                      h_reset,
  input  logic [V_WIDTH-1:0]                      v_reset,
  input  logic                                    f_reset,
  output logic                                    start_of_sample,
  output logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] sample_ticks,
  output logic                                    new_line,
  output logic                                    new_frame,
  output logic                                    field,
  output logic [H_WIDTH-1:0]                      h_count,
  output logic [V_WIDTH-1:0]                      v_count
);

  logic                        count_sample;
  logic [TOTAL_CALC_WIDTH-1:0] h_last_full;
  logic [TOTAL_CALC_WIDTH-1:0] v_last_full;
  logic [H_WIDTH-1:0]          h_total_int;
  logic [V_WIDTH-1:0]          v_total_int;
  logic [V_WIDTH-1:0]          next_line;
  logic                        unused_total_bits;

  alt_vipcti131_common_sample_tick_counter #(
    .NUMBER_OF_COLOUR_PLANES       (NUMBER_OF_COLOUR_PLANES),
    .COLOUR_PLANES_ARE_IN_PARALLEL (COLOUR_PLANES_ARE_IN_PARALLEL),
    .TICK_WIDTH                    (LOG2_NUMBER_OF_COLOUR_PLANES)
  ) u_tick_counter (
    .clk             (clk),
    .rst             (rst),
    .sclr            (sclr),
    .enable          (enable),
    .hd_sdn          (hd_sdn),
    .ticks           (sample_ticks),
    .start_of_sample (start_of_sample),
    .count_sample    (count_sample)
  );

  assign h_last_full = total_to_last(TOTAL_CALC_WIDTH'(h_total), TOTALS_MINUS_ONE != 0);
  assign v_last_full = total_to_last(TOTAL_CALC_WIDTH'(v_total), TOTALS_MINUS_ONE != 0);
  assign h_total_int = h_last_full[H_WIDTH-1:0];
  assign v_total_int = v_last_full[V_WIDTH-1:0];
  assign unused_total_bits = ^{h_last_full[TOTAL_CALC_WIDTH-1:H_WIDTH],
                               v_last_full[TOTAL_CALC_WIDTH-1:V_WIDTH]};

  // >= rather than == so a total shrunk below the current position wraps at
  // the next sample instead of running on to the counter limit.
  assign new_line  = count_sample & (h_count >= h_total_int);
  assign new_frame = new_line & (v_count >= v_total_int);
  assign next_line = new_frame ? '0 : v_count + V_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      h_count <= '0;
      v_count <= '0;
    end else if (sclr) begin
      h_count <= h_reset;
      v_count <= v_reset;
    end else if (new_line) begin
      h_count <= '0;
      v_count <= next_line;
    end else if (count_sample) begin
      h_count <= h_count + H_WIDTH'(1);
    end
  end

  generate
    if (INTERLACED_SUPPORT != 0) begin : g_field
      // The field flag follows the line being entered; fall beats rise.
      always_ff @(posedge clk) begin
        if (rst) begin
          field <= 1'b0;
        end else if (sclr) begin
          field <= f_reset & interlaced;
        end else if (new_line) begin
          if (!interlaced) begin
            field <= 1'b0;
          end else if (next_line == f_fall_line) begin
            field <= 1'b0;
          end else if (next_line == f_rise_line) begin
            field <= 1'b1;
          end
        end
      end
    end else begin : g_no_field
      logic unused_field_inputs;
      assign unused_field_inputs = ^{interlaced, f_reset, f_rise_line, f_fall_line};
      assign field               = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_alt_vipcti131_common_field_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alt_vipcti131_common_field_counter
// Directed and random-gap checks of the field counter against a queued model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_alt_vipcti131_common_field_counter;

  localparam int HW = 14;
  localparam int VW = 13;

  logic          clk = 1'b0;
  logic          rst, sclr, enable, hd_sdn, interlaced, f_reset;
  logic [HW-1:0] h_total, h_reset;
  logic [VW-1:0] v_total, v_reset, f_rise_line, f_fall_line;
  logic          start_of_sample, new_line, new_frame, field;
  logic [1:0]    sample_ticks;
  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;

  typedef struct {
    int ticks;
    int sos;
    int nl;
    int nf;
    int field;
    int h;
    int v;
  } exp_t;

  exp_t  sb[$];
  int    m_ticks, m_h, m_v, m_f;
  int    vectors     = 0;
  int    miscompares = 0;
  int    last_nl, last_nf, last_sos;
  string sec = "reset";

  always #5 clk = ~clk;

  alt_vipcti131_common_field_counter #(
    .COLOUR_PLANES_ARE_IN_PARALLEL (0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .sclr            (sclr),
    .enable          (enable),
    .hd_sdn          (hd_sdn),
    .interlaced      (interlaced),
    .h_total         (h_total),
    .v_total         (v_total),
    .f_rise_line     (f_rise_line),
    .f_fall_line     (f_fall_line),
    .h_reset         (h_reset),
    .v_reset         (v_reset),
    .f_reset         (f_reset),
    .start_of_sample (start_of_sample),
    .sample_ticks    (sample_ticks),
    .new_line        (new_line),
    .new_frame       (new_frame),
    .field           (field),
    .h_count         (h_count),
    .v_count         (v_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s.%s observed=%0d expected=%0d", sec, tag, obs, exp);
    end
  endtask

  // One clock: model predicts, expectation queued, DUT sampled mid-cycle.
  task automatic step();
    exp_t e;
    int   ht, vt, cs, nxt, seq;
    seq = hd_sdn ? 0 : 1;
    ht  = (h_total == '0) ? 0 : int'(h_total) - 1;
    vt  = (v_total == '0) ? 0 : int'(v_total) - 1;
    cs  = (enable && (seq == 0 || m_ticks == 2)) ? 1 : 0;
    e.ticks = m_ticks;
    e.sos   = (enable && m_ticks == 0) ? 1 : 0;
    e.nl    = (cs == 1 && m_h >= ht) ? 1 : 0;
    e.nf    = (e.nl == 1 && m_v >= vt) ? 1 : 0;
    e.field = m_f;
    e.h     = m_h;
    e.v     = m_v;
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    last_nl  = int'(new_line);
    last_nf  = int'(new_frame);
    last_sos = int'(start_of_sample);
    check("ticks",     32'(sample_ticks),    32'(e.ticks));
    check("sos",       32'(start_of_sample), 32'(e.sos));
    check("new_line",  32'(new_line),        32'(e.nl));
    check("new_frame", 32'(new_frame),       32'(e.nf));
    check("field",     32'(field),           32'(e.field));
    check("h_count",   32'(h_count),         32'(e.h));
    check("v_count",   32'(v_count),         32'(e.v));
    if (rst) begin
      m_ticks = 0; m_h = 0; m_v = 0; m_f = 0;
    end else if (sclr) begin
      m_ticks = 0;
      m_h     = int'(h_reset);
      m_v     = int'(v_reset);
      m_f     = (f_reset && interlaced) ? 1 : 0;
    end else begin
      nxt = (e.nf == 1) ? 0 : (m_v + 1) % (1 << VW);
      if (e.nl == 1) begin
        m_h = 0;
        m_v = nxt;
        if (!interlaced)                  m_f = 0;
        else if (nxt == int'(f_fall_line)) m_f = 0;
        else if (nxt == int'(f_rise_line)) m_f = 1;
      end else if (cs == 1) begin
        m_h = (m_h + 1) % (1 << HW);
      end
      if (seq == 0)    m_ticks = 0;
      else if (enable) m_ticks = (m_ticks == 2) ? 0 : m_ticks + 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; sclr = 1'b0; enable = 1'b0; hd_sdn = 1'b1; interlaced = 1'b0;
    h_total = 14'd4; v_total = 13'd3; f_rise_line = '0; f_fall_line = '0;
    h_reset = '0; v_reset = '0; f_reset = 1'b0;
    m_ticks = 0; m_h = 0; m_v = 0; m_f = 0;
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;

    // Parallel: 4 samples per line, 3 lines per frame.
    sec = "parallel";
    enable = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      step();
      check("frame_on_cycle12", 32'(last_nf), (c == 12) ? 32'd1 : 32'd0);
      if (c == 4)  check("v_after_line1", 32'(v_count), 32'd1);
      if (c == 8)  check("v_after_line2", 32'(v_count), 32'd2);
      if (c == 12) check("v_after_frame", 32'(v_count), 32'd0);
    end

    // Sequential planes, then HD override.
    sec = "sequential";
    hd_sdn = 1'b0; h_total = 14'd100; v_total = 13'd100;
    sclr = 1'b1; step(); sclr = 1'b0;
    for (int c = 0; c < 9; c++) step();
    check("h_after_9_seq", 32'(h_count), 32'd3);
    hd_sdn = 1'b1;
    for (int c = 0; c < 4; c++) step();
    check("h_after_4_hd", 32'(h_count), 32'd7);
    check("ticks_hd", 32'(sample_ticks), 32'd0);

    // Interlaced field tracking, one-sample lines.
    sec = "interlaced";
    h_total = 14'd1; v_total = 13'd10; f_rise_line = 13'd5; f_fall_line = 13'd0;
    interlaced = 1'b1;
    sclr = 1'b1; step(); sclr = 1'b0;
    for (int c = 0; c < 5; c++) step();
    check("field_rise_v", 32'(v_count), 32'd5);
    check("field_rise", 32'(field), 32'd1);
    for (int c = 0; c < 17; c++) step();
    sec = "fall_wins";
    f_rise_line = 13'd5; f_fall_line = 13'd5;
    for (int c = 0; c < 12; c++) begin
      step();
      check("field_low", 32'(field), 32'd0);
    end

    // Preload mid-line, then reset beating preload.
    sec = "preload";
    h_total = 14'd100; v_total = 13'd100;
    for (int c = 0; c < 3; c++) step();
    h_reset = 14'd2; v_reset = 13'd7; f_reset = 1'b1;
    sclr = 1'b1; step(); sclr = 1'b0;
    check("h_preload", 32'(h_count), 32'd2);
    check("v_preload", 32'(v_count), 32'd7);
    check("f_preload", 32'(field), 32'd1);
    rst = 1'b1; sclr = 1'b1; step(); rst = 1'b0; sclr = 1'b0;
    check("h_rst_over_sclr", 32'(h_count), 32'd0);
    check("v_rst_over_sclr", 32'(v_count), 32'd0);
    check("f_rst_over_sclr", 32'(field), 32'd0);

    // Zero total: every counted sample ends a line.
    sec = "zero_total";
    hd_sdn = 1'b0; h_total = 14'd0;
    for (int c = 0; c < 9; c++) begin
      step();
      check("nl_every_sample", 32'(last_nl), (c % 3 == 2) ? 32'd1 : 32'd0);
    end

    // Shrinking total below the current position.
    sec = "shrink";
    hd_sdn = 1'b1; h_total = 14'd100; v_total = 13'd1000;
    h_reset = 14'd50; v_reset = 13'd0; f_reset = 1'b0;
    sclr = 1'b1; step(); sclr = 1'b0;
    h_total = 14'd10;
    step();
    check("nl_after_shrink", 32'(last_nl), 32'd1);
    check("h_wrapped", 32'(h_count), 32'd0);

    // Random enable gaps.
    sec = "gaps";
    h_total = 14'd5; v_total = 13'd4; f_rise_line = 13'd2; f_fall_line = 13'd0;
    for (int c = 0; c < 300; c++) begin
      enable = 1'($urandom_range(0, 1));
      hd_sdn = (c < 150) ? 1'b0 : 1'b1;
      step();
      if (!enable) begin
        check("idle_new_line", 32'(last_nl), 32'd0);
        check("idle_sos", 32'(last_sos), 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
